// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

  // Active-high segment patterns, bit0 = a ... bit6 = g; b and d are lower case.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment driver with blanking gaps, per-digit
// blink and a valid/ready load port committed only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES   = 12500,
  parameter int unsigned BLANK_CYCLES   = 250,
  parameter int unsigned BLINK_HALF     = 25000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [15:0]           load_digits,
  input  logic [NUM_DIGITS-1:0] load_dp,
  input  logic [NUM_DIGITS-1:0] load_blink,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done,
  output logic                  blink_phase
);

  localparam int unsigned SCAN_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{EN_ACTIVE_LOW}};

  scan_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic                  fdone_q, fdone_d;

  logic [15:0]           act_dig_q, act_dig_d, pend_dig_q;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q;
  logic [NUM_DIGITS-1:0] act_blk_q, act_blk_d, pend_blk_q;
  logic                  pend_q, pend_d;
  logic                  capture, commit;

  logic [6:0]            seg_q, seg_d, hex_seg;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  lit;

  assign capture = load_valid && !pend_q;
  // The boundary acts in the cycle frame_done is high, so a capture made in
  // that same cycle lands in pending and waits a full frame.
  assign commit  = fdone_q && pend_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = CW'(cnt_q + 1'b1);
    fdone_d = 1'b0;
    case (state_q)
      BLANK: if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
        state_d = ON;
        cnt_d   = '0;
      end
      ON: if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : IW'(idx_q + 1'b1);
        fdone_d = (idx_q == IW'(NUM_DIGITS - 1));
      end
      default: state_d = BLANK;
    endcase

    bcnt_d  = (bcnt_q == BW'(BLINK_HALF - 1)) ? '0 : BW'(bcnt_q + 1'b1);
    phase_d = phase_q ^ (bcnt_q == BW'(BLINK_HALF - 1));

    pend_d    = commit ? 1'b0 : (capture ? 1'b1 : pend_q);
    act_dig_d = commit ? pend_dig_q : act_dig_q;
    act_dp_d  = commit ? pend_dp_q  : act_dp_q;
    act_blk_d = commit ? pend_blk_q : act_blk_q;
  end

  seg_hex_decode u_dec (
    .nibble_i (act_dig_d[{idx_d, 2'b00} +: 4]),
    .seg_o    (hex_seg)
  );

  // Outputs are built from next-state values so that, in any cycle, they
  // agree with the registered state, index and blink_phase of that cycle.
  always_comb begin
    lit  = (state_d == ON) && !(act_blk_d[idx_d] && phase_d);
    seg_d = (lit ? hex_seg : 7'h00) ^ SEG_OFF;
    dp_d  = (lit && act_dp_d[idx_d]) ^ DP_OFF;
    en_d  = (lit ? (NUM_DIGITS'(1) << idx_d) : '0) ^ EN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      idx_q      <= '0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      fdone_q    <= 1'b0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      act_blk_q  <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_blk_q <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      en_q       <= EN_OFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      fdone_q   <= fdone_d;
      act_dig_q <= act_dig_d;
      act_dp_q  <= act_dp_d;
      act_blk_q <= act_blk_d;
      pend_q    <= pend_d;
      if (capture) begin
        pend_dig_q <= load_digits;
        pend_dp_q  <= load_dp;
        pend_blk_q <= load_blink;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      en_q  <= en_d;
    end
  end

  assign load_ready  = !pend_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign dig_en      = en_q;
  assign frame_done  = fdone_q;
  assign blink_phase = phase_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads against a
// timeline model (slot position derived from cycles since reset release).
module tb_seg_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int BH = 40;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_digits = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  load_blink = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_en;
  logic        frame_done;
  logic        blink_phase;

  int checks = 0;
  int failures = 0;
  int t = 0;

  logic [15:0] m_act_dig, m_pend_dig;
  logic [3:0]  m_act_dp, m_act_blk, m_pend_dp, m_pend_blk;
  bit          m_pend;

  seg_scan_ctrl #(
    .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_HALF(BH),
    .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_digits(load_digits), .load_dp(load_dp), .load_blink(load_blink),
    .seg(seg), .dp(dp), .dig_en(dig_en),
    .frame_done(frame_done), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_act_dig = '0; m_act_dp = '0; m_act_blk = '0;
    m_pend_dig = '0; m_pend_dp = '0; m_pend_blk = '0;
    m_pend = 1'b0;
  endtask

  // Called at a negedge: check cycle t, drive inputs for its closing edge,
  // advance the model, then move to the next negedge.
  task automatic cyc(input bit v, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    int slot, k;
    bit on, ph, lit, fd;
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    slot = t % FRAME;
    k    = slot / SLOT;
    on   = (slot % SLOT) >= BC;
    ph   = ((t / BH) % 2) == 1;
    lit  = on && !(m_act_blk[k] && ph);
    fd   = (t > 0) && (slot == 0);
    e_en  = lit ? ~(4'b0001 << k) : 4'hF;
    e_seg = lit ? ~hexseg(m_act_dig[4*k +: 4]) : 7'h7F;
    e_dp  = lit ? ~m_act_dp[k] : 1'b1;
    chk("dig_en", 32'(dig_en), 32'(e_en));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_done", 32'(frame_done), 32'(fd));
    chk("load_ready", 32'(load_ready), 32'(!m_pend));
    chk("blink_phase", 32'(blink_phase), 32'(ph));
    load_valid = v; load_digits = d; load_dp = p; load_blink = b;
    if (fd && m_pend) begin
      m_act_dig = m_pend_dig; m_act_dp = m_pend_dp; m_act_blk = m_pend_blk;
      m_pend = 1'b0;
    end else if (v && !m_pend) begin
      m_pend_dig = d; m_pend_dp = p; m_pend_blk = b;
      m_pend = 1'b1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dig_en", 32'(dig_en), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_blink_phase", 32'(blink_phase), 32'h0);

    // 1: free scan from reset, data inputs ignored without valid
    rst_n = 1'b1;
    model_reset();
    while (t < 55) idle();

    // 2: mid-frame load held until the boundary
    cyc(1'b1, 16'h1A3F, 4'b0100, 4'b0000);
    chk("ready_drop", 32'(load_ready), 32'h0);
    while (t < 120) idle();

    // 3: load presented exactly on the frame_done cycle
    for (int i = 0; i < 200 && !((t % FRAME) == 0 && !m_pend); i++) idle();
    chk("s3_boundary_ready", 32'(load_ready), 32'h1);
    cyc(1'b1, 16'($urandom), 4'($urandom), 4'b0000);
    repeat (90) idle();

    // 4: blink digit 1 across several phase changes
    for (int i = 0; i < 200 && m_pend; i++) idle();
    cyc(1'b1, 16'h8E52, 4'($urandom), 4'b0010);
    repeat (170) idle();

    // 5: reset during digit 2's lit window with a load pending
    for (int i = 0; i < 200 && !((t % FRAME) == 5 && !m_pend); i++) idle();
    cyc(1'b1, 16'hC0DE, 4'b1111, 4'b0000);
    for (int i = 0; i < 200 && (t % FRAME) != 25; i++) idle();
    chk("s5_pending", 32'(load_ready), 32'h0);
    chk("s5_lit", 32'(dig_en), 32'hB);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_async_en", 32'(dig_en), 32'hF);
    chk("s5_async_seg", 32'(seg), 32'h7F);
    chk("s5_async_dp", 32'(dp), 32'h1);
    chk("s5_async_ready", 32'(load_ready), 32'h1);
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (100) idle();

    // 6: valid held high with changing data
    repeat (250) cyc(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));

    // random traffic
    repeat (300) cyc(($urandom % 4) == 0, 16'($urandom), 4'($urandom), 4'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan controller that shares one 7-segment bus (a..g plus dp) among four common-enable digits by time multiplexing. It holds four hex nibbles, drives one digit at a time with a blanking gap between digits to suppress ghosting, and supports per-digit blinking. New display contents arrive over a valid/ready load port and are committed only at a frame boundary, so a frame never shows mixed old and new data. It sits between application logic and the board's display pins.

Parameters:
DIGIT_CYCLES, 12500, clk cycles each digit is lit (4 kHz digit rate at 50 MHz); min 1
BLANK_CYCLES, 250, clk cycles all digits are off between digits; min 1
BLINK_HALF, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz); min 1
SEG_ACTIVE_LOW, 1, 1 = segment lit when pin is 0
EN_ACTIVE_LOW, 1, 1 = digit enabled when pin is 0

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  load request
load_ready  out  1  pending slot empty, load accepted
load_digits  in  16  nibble k = hex value of digit k
load_dp  in  4  decimal-point enable per digit
load_blink  in  4  blink enable per digit
seg  out  7  segments; seg[0]=a ... seg[6]=g, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, same polarity as seg
dig_en  out  4  digit enables, polarity per EN_ACTIVE_LOW
frame_done  out  1  one-cycle pulse at each frame boundary
blink_phase  out  1  0 = blinking digits visible, 1 = blinking digits hidden

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- While reset is asserted: state BLANK, digit index 0, all counters 0, active and pending registers 0, pending flag 0, blink_phase 0, load_ready 1, frame_done 0, seg/dp/dig_en all inactive at the configured polarity. Reset mid-frame aborts the scan immediately and discards pending data.
- FSM states: BLANK and ON.
  - BLANK: all digits off, segments off, for BLANK_CYCLES cycles, then go to ON.
  - ON: lit for DIGIT_CYCLES cycles, then go to BLANK with index = (index+1) mod 4.
  - Per-digit period is BLANK_CYCLES+DIGIT_CYCLES. Frame = 4 × that.
- After reset release, digit 0 is first lit on cycle BLANK_CYCLES.
- All display outputs are registered. dig_en, seg and dp switch on the same edge. Exactly one enable is active in ON; none is active in BLANK.
- In ON with index k:
  - seg = hex decode of active nibble k: standard 0-9, A, b, C, d, E, F.
  - dp = active_dp[k].
  - If active_blink[k]=1 and blink_phase=1, dig_en stays inactive and seg/dp are off for that slot. Timing is unchanged.
- frame_done pulses for one cycle on the ON→BLANK transition when index=3 (frame boundary).
- Load handshake:
  - load_ready = !pending.
  - On a cycle with load_valid && load_ready, the inputs are captured into the pending registers and pending is set.
  - At a frame boundary with pending=1, pending is copied to active and cleared. load_ready returns high on the next cycle.
  - A capture in the same cycle as a frame boundary is not committed at that boundary; it is committed at the next one.
  - load_valid while load_ready=0 is ignored. The producer must hold its data.
- Blink timer:
  - Free-running, counts 0..BLINK_HALF-1 and wraps.
  - blink_phase toggles on the wrap.
  - Independent of the scan; not affected by loads.
- Width rules:
  - Counters are sized with $clog2 of their maximum value (at least 1 bit).
  - Counter compares are against value−1, with no off-by-one at the wrap.
  - Index wraps 3→0.

Decomposition:
- Package seg_pkg holds:
  - the FSM state enum {BLANK, ON};
  - the 16-entry hex-to-segment constant table (active-high, a=bit0);
  - the NUM_DIGITS=4 constant.
- Sub-module seg_hex_decode: combinational, 4-bit in, 7-bit active-high out. The polarity inversion is applied in seg_scan_ctrl.

Test Plan:
All scenarios use DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_HALF=40, both polarities active-low.
1. Release reset, no load -> dig_en=4'hF for 2 cycles; then dig_en=4'hE, seg=7'h40 ("0") for 8 cycles; 2 cycles all off; then dig_en=4'hD. frame_done first pulses at cycle 40.
2. Load digits=16'h1A3F, dp=4'b0100 mid-frame -> load_ready drops the next cycle. Old data is shown until frame_done, then the digits show F, 3, A, 1 with dp lit only on digit 2. load_ready goes high 1 cycle after frame_done.
3. load_valid asserted on the frame_done cycle with load_ready=1 -> data is captured but not shown that frame; it is committed at the following frame_done.
4. blink=4'b0010 -> digit 1's enable stays inactive for the 8 ON cycles while blink_phase=1. It reappears after blink_phase toggles at the 40-cycle wrap. Other digits are unaffected.
5. Assert rst_n low during digit 2's ON window -> seg/dp/dig_en go inactive asynchronously, load_ready=1, and the pending load is discarded. After release, the scan restarts at digit 0 after 2 blank cycles.
6. Hold load_valid high continuously with changing data -> exactly one capture per frame, always the value present on the cycle load_ready is high. No two loads are committed at the same boundary.
